piso_tx: RTL and testbench

//   Parallel-in serial-out transmitter: accepts a WIDTH-bit word over a valid/ready handshake and

---
 rtl/piso_tx_if.sv | 23 ++
 rtl/piso_tx.sv | 123 ++++++++++++
 tb/tb_piso_tx.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/piso_tx_if.sv
// Handshake and serial-output bundle for the parallel-in serial-out transmitter.
// The master side drives the word; the slave side (the transmitter) drives the serial outputs.
interface piso_tx_if #(
   parameter int unsigned WIDTH = 4
);
   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             din_ready;
   logic             sout;
   logic             sout_en;
   logic             busy;
   logic             done;

   modport master (
      output din, din_valid,
      input  din_ready, sout, sout_en, busy, done
   );

   modport slave (
      input  din, din_valid,
      output din_ready, sout, sout_en, busy, done
   );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: takes a word over valid/ready and shifts it out LSB first,
// with a frame-enable strobe, a done pulse after each frame and an optional idle gap.
module piso_tx #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned GAP   = 0
) (
   input  logic     clk,
   input  logic     rst,
   piso_tx_if.slave bus
);

   localparam int unsigned BW       = $clog2(WIDTH + 1);
   localparam int unsigned GW       = (GAP > 0) ? $clog2(GAP + 1) : 1;
   localparam int unsigned BIT_LAST = WIDTH - 1;
   localparam int unsigned GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_shreg;
   logic [WIDTH-1:0] w_shreg_nxt;
   logic [BW-1:0]    r_bitcnt;
   logic [BW-1:0]    w_bitcnt_nxt;
   logic [GW-1:0]    r_gapcnt;
   logic [GW-1:0]    w_gapcnt_nxt;
   logic             r_sout;
   logic             w_sout_nxt;
   logic             r_sout_en;
   logic             w_sout_en_nxt;
   logic             r_busy;
   logic             w_busy_nxt;
   logic             r_done;
   logic             w_done_nxt;

   // State and datapath registers; reset aborts any frame without a done pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_shreg   <= '0;
         r_bitcnt  <= '0;
         r_gapcnt  <= '0;
         r_sout    <= 1'b0;
         r_sout_en <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_shreg   <= w_shreg_nxt;
         r_bitcnt  <= w_bitcnt_nxt;
         r_gapcnt  <= w_gapcnt_nxt;
         r_sout    <= w_sout_nxt;
         r_sout_en <= w_sout_en_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
      end
   end

   // Next-state and next-output decode; sout is preloaded at the accept edge for 1-cycle latency
   always_comb begin
      w_state_nxt   = r_state;
      w_shreg_nxt   = r_shreg;
      w_bitcnt_nxt  = r_bitcnt;
      w_gapcnt_nxt  = r_gapcnt;
      w_sout_nxt    = 1'b0;
      w_sout_en_nxt = 1'b0;
      w_done_nxt    = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (bus.din_valid) begin
               w_state_nxt   = S_SHIFT;
               w_shreg_nxt   = bus.din;
               w_bitcnt_nxt  = '0;
               w_sout_nxt    = bus.din[0];
               w_sout_en_nxt = 1'b1;
            end
         end

         S_SHIFT: begin
            w_shreg_nxt  = r_shreg >> 1;
            w_bitcnt_nxt = r_bitcnt + BW'(1);
            if (r_bitcnt == BW'(BIT_LAST)) begin
               w_done_nxt = 1'b1;
               if (GAP > 0) begin
                  w_state_nxt  = S_GAP;
                  w_gapcnt_nxt = '0;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end else begin
               w_sout_nxt    = r_shreg[1];
               w_sout_en_nxt = 1'b1;
            end
         end

         S_GAP: begin
            if (r_gapcnt == GW'(GAP_LAST)) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_gapcnt_nxt = r_gapcnt + GW'(1);
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign w_busy_nxt = (w_state_nxt != S_IDLE);

   assign bus.din_ready = (r_state == S_IDLE) && !rst;
   assign bus.sout      = r_sout;
   assign bus.sout_en   = r_sout_en;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: a 4-bit/no-gap instance and an 8-bit/3-cycle-gap instance,
// serial bits checked against a scoreboard of expected bits and a shift-register receiver model.
module tb_piso_tx;

   logic clk;
   logic rst;

   piso_tx_if #(.WIDTH(4)) a_if ();
   piso_tx_if #(.WIDTH(8)) b_if ();

   piso_tx #(.WIDTH(4), .GAP(0)) u_dut_a (.clk(clk), .rst(rst), .bus(a_if));
   piso_tx #(.WIDTH(8), .GAP(3)) u_dut_b (.clk(clk), .rst(rst), .bus(b_if));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_cmp;
   int   n_err;
   int   done_a;
   int   done_b;
   logic q_a[$];
   logic q_b[$];
   logic [3:0] rx_a;
   logic [7:0] rx_b;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_a(input logic [3:0] w);
      for (int i = 0; i < 4; i++) q_a.push_back(w[i]);
   endtask

   task automatic push_b(input logic [7:0] w);
      for (int i = 0; i < 8; i++) q_b.push_back(w[i]);
   endtask

   // One clock: sample 1ns after the edge, score serial bits of both instances
   task automatic tick();
      logic e;
      @(posedge clk);
      #1;
      if (a_if.sout_en === 1'b1) begin
         if (q_a.size() == 0) check("a_unexpected_bit", 32'(a_if.sout_en), 32'd0);
         else begin
            e = q_a.pop_front();
            check("a_bit", 32'(a_if.sout), 32'(e));
            rx_a = {a_if.sout, rx_a[3:1]};
         end
      end else begin
         check("a_idle_sout", 32'(a_if.sout), 32'd0);
      end
      if (b_if.sout_en === 1'b1) begin
         if (q_b.size() == 0) check("b_unexpected_bit", 32'(b_if.sout_en), 32'd0);
         else begin
            e = q_b.pop_front();
            check("b_bit", 32'(b_if.sout), 32'(e));
            rx_b = {b_if.sout, rx_b[7:1]};
         end
      end else begin
         check("b_idle_sout", 32'(b_if.sout), 32'd0);
      end
      if (a_if.done === 1'b1) done_a++;
      if (b_if.done === 1'b1) done_b++;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      done_a = 0;
      done_b = 0;
      rx_a = '0;
      rx_b = '0;
      rst = 1'b1;
      a_if.din = '0;
      a_if.din_valid = 1'b1;
      b_if.din = '0;
      b_if.din_valid = 1'b0;

      // Reset held two cycles, din_valid high must be ignored
      repeat (2) begin
         tick();
         check("rst_sout_en", 32'(a_if.sout_en), 32'd0);
         check("rst_busy", 32'(a_if.busy), 32'd0);
         check("rst_done", 32'(a_if.done), 32'd0);
         check("rst_ready", 32'(a_if.din_ready), 32'd0);
         check("rst_ready_b", 32'(b_if.din_ready), 32'd0);
      end
      a_if.din_valid = 1'b0;
      rst = 1'b0;
      #1;
      check("ready_after_rst", 32'(a_if.din_ready), 32'd1);
      tick();
      check("no_accept_in_rst", 32'(a_if.busy), 32'd0);

      // Single frame 4'b1011
      done_a = 0;
      a_if.din = 4'b1011;
      a_if.din_valid = 1'b1;
      push_a(4'b1011);
      tick();
      check("t2_first_en", 32'(a_if.sout_en), 32'd1);
      check("t2_busy", 32'(a_if.busy), 32'd1);
      check("t2_ready", 32'(a_if.din_ready), 32'd0);
      a_if.din_valid = 1'b0;
      repeat (3) tick();
      tick();
      check("t2_done", 32'(a_if.done), 32'd1);
      check("t2_en_low", 32'(a_if.sout_en), 32'd0);
      check("t2_busy_low", 32'(a_if.busy), 32'd0);
      check("t2_ready_with_done", 32'(a_if.din_ready), 32'd1);
      check("t2_rx", 32'(rx_a), 32'hB);
      tick();
      check("t2_done_1cyc", 32'(a_if.done), 32'd0);
      check("t2_done_cnt", 32'(done_a), 32'd1);

      // Back-to-back 4'hA then 4'h5 with valid held
      done_a = 0;
      a_if.din = 4'hA;
      a_if.din_valid = 1'b1;
      push_a(4'hA);
      tick();
      a_if.din = 4'h5;
      push_a(4'h5);
      repeat (3) tick();
      check("t3_rx_a", 32'(rx_a), 32'hA);
      tick();
      check("t3_gap_en", 32'(a_if.sout_en), 32'd0);
      check("t3_gap_ready", 32'(a_if.din_ready), 32'd1);
      tick();
      check("t3_second_en", 32'(a_if.sout_en), 32'd1);
      a_if.din_valid = 1'b0;
      repeat (4) tick();
      check("t3_rx_5", 32'(rx_a), 32'h5);
      check("t3_done_cnt", 32'(done_a), 32'd2);
      check("t3_q_empty", 32'(q_a.size()), 32'd0);

      // Busy-ignore: 4'hC pulsed mid-frame must not be sent
      done_a = 0;
      a_if.din = 4'h3;
      a_if.din_valid = 1'b1;
      push_a(4'h3);
      tick();
      a_if.din_valid = 1'b0;
      tick();
      a_if.din = 4'hC;
      a_if.din_valid = 1'b1;
      tick();
      a_if.din_valid = 1'b0;
      repeat (4) tick();
      check("t4_rx", 32'(rx_a), 32'h3);
      check("t4_done_cnt", 32'(done_a), 32'd1);
      check("t4_idle_busy", 32'(a_if.busy), 32'd0);

      // Mid-frame reset after two bits of 4'hF
      done_a = 0;
      a_if.din = 4'hF;
      a_if.din_valid = 1'b1;
      push_a(4'hF);
      tick();
      a_if.din_valid = 1'b0;
      tick();
      rst = 1'b1;
      q_a.delete();
      tick();
      check("t5_en", 32'(a_if.sout_en), 32'd0);
      check("t5_sout", 32'(a_if.sout), 32'd0);
      check("t5_busy", 32'(a_if.busy), 32'd0);
      check("t5_done", 32'(a_if.done), 32'd0);
      rst = 1'b0;
      tick();
      check("t5_no_done", 32'(done_a), 32'd0);
      a_if.din = 4'h6;
      a_if.din_valid = 1'b1;
      push_a(4'h6);
      tick();
      a_if.din_valid = 1'b0;
      repeat (4) tick();
      check("t5_rx", 32'(rx_a), 32'h6);
      check("t5_done_cnt", 32'(done_a), 32'd1);
      check("t5_q_empty", 32'(q_a.size()), 32'd0);

      // 8-bit frame with a 3-cycle gap
      done_b = 0;
      b_if.din = 8'hA5;
      b_if.din_valid = 1'b1;
      push_b(8'hA5);
      tick();
      b_if.din_valid = 1'b0;
      repeat (7) tick();
      check("t6_last_en", 32'(b_if.sout_en), 32'd1);
      tick();
      check("t6_done", 32'(b_if.done), 32'd1);
      check("t6_gap_ready0", 32'(b_if.din_ready), 32'd0);
      check("t6_gap_busy0", 32'(b_if.busy), 32'd1);
      check("t6_rx", 32'(rx_b), 32'hA5);
      tick();
      check("t6_gap_ready1", 32'(b_if.din_ready), 32'd0);
      check("t6_gap_done1", 32'(b_if.done), 32'd0);
      tick();
      check("t6_gap_ready2", 32'(b_if.din_ready), 32'd0);
      check("t6_gap_busy2", 32'(b_if.busy), 32'd1);
      tick();
      check("t6_ready_back", 32'(b_if.din_ready), 32'd1);
      check("t6_busy_low", 32'(b_if.busy), 32'd0);
      check("t6_done_cnt", 32'(done_b), 32'd1);
      check("t6_q_empty", 32'(q_b.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
